// File: rtl/dmem_port_sched.sv
// Arbitrates the single data-memory port between loads and the finished-store drain,
// forwarding a pending store's data to a same-address load without touching memory.
module dmem_port_sched #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 33,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_valid,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] st_data,
   output logic              st_done,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              ld_grant,
   output logic              ld_valid,
   output logic [DATA_W-1:0] ld_data,
   output logic              ld_fwd,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, LD_WAIT, ST_WAIT} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                ld_valid_q, ld_valid_d;
   logic [DATA_W-1:0]   ld_data_q, ld_data_d;
   logic                ld_fwd_q, ld_fwd_d;

   logic                fwd_hit;
   logic                st_win;
   logic [CNT_W-1:0]    cnt_inc;

   assign fwd_hit = ld_req & st_valid & (ld_addr == st_addr);
   // Loads win over a pending store until they have been granted STARVE_MAX times in a row.
   assign st_win  = st_valid & (~ld_req | (cnt_q == CNT_MAX));
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ld_valid_d  = 1'b0;
      ld_data_d   = ld_data_q;
      ld_fwd_d    = 1'b0;
      ld_grant    = 1'b0;
      st_done     = 1'b0;

      case (state_q)
         IDLE: begin
            if (fwd_hit) begin
               ld_grant   = 1'b1;
               ld_valid_d = 1'b1;
               ld_fwd_d   = 1'b1;
               ld_data_d  = st_data;
               cnt_d      = cnt_inc;
            end else if (st_win) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = st_addr;
               mem_wdata_d = st_data;
               state_d     = ST_WAIT;
               cnt_d       = '0;
            end else if (ld_req) begin
               ld_grant   = 1'b1;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = ld_addr;
               state_d    = LD_WAIT;
               cnt_d      = st_valid ? cnt_inc : '0;
            end
         end
         LD_WAIT: begin
            if (mem_ack) begin
               mem_req_d  = 1'b0;
               ld_valid_d = 1'b1;
               ld_data_d  = mem_rdata;
               state_d    = IDLE;
            end
         end
         ST_WAIT: begin
            st_done = mem_ack;
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (!st_valid) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ld_valid_q  <= 1'b0;
         ld_data_q   <= '0;
         ld_fwd_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ld_valid_q  <= ld_valid_d;
         ld_data_q   <= ld_data_d;
         ld_fwd_q    <= ld_fwd_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign ld_valid  = ld_valid_q;
   assign ld_data   = ld_data_q;
   assign ld_fwd    = ld_fwd_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_port_sched.sv
// Bench for dmem_port_sched: directed vectors, expected events queued at issue and
// consumed by a negedge monitor, plus direct cycle-accurate checks.
module tb_dmem_port_sched;

   localparam int AW = 5;
   localparam int DW = 33;

   localparam logic [1:0] K_GRANT = 2'd0;
   localparam logic [1:0] K_ISSUE = 2'd1;
   localparam logic [1:0] K_LDV   = 2'd2;
   localparam logic [1:0] K_STD   = 2'd3;

   typedef struct packed {
      logic [1:0]    kind;
      logic          we;
      logic          fwd;
      logic [AW-1:0] addr;
      logic [DW-1:0] dat;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          st_valid;
   logic [AW-1:0] st_addr;
   logic [DW-1:0] st_data;
   logic          st_done;
   logic          ld_req;
   logic [AW-1:0] ld_addr;
   logic          ld_grant;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_fwd;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   dmem_port_sched #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_done(st_done),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_grant(ld_grant),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_fwd(ld_fwd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int  n_chk  = 0;
   int  n_pass = 0;
   ev_t exp_q[$];
   logic req_prev = 1'b0;
   logic sd_seen  = 1'b0;
   int  ack_dly   = 0;
   int  wait_cnt  = 0;
   logic [DW-1:0] rd_val = '0;

   function automatic ev_t mk_ev(logic [1:0] k, logic we, logic fwd, logic [AW-1:0] a, logic [DW-1:0] d);
      ev_t e;
      e.kind = k; e.we = we; e.fwd = fwd; e.addr = a; e.dat = d;
      return e;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic cmp_ev(ev_t act);
      ev_t e;
      logic ok;
      n_chk++;
      if (exp_q.size() == 0) begin
         $display("FAIL sb_unexpected: got kind=%0d we=%0d fwd=%0d addr=%h dat=%h, expected no event (t=%0t)",
                  act.kind, act.we, act.fwd, act.addr, act.dat, $time);
      end else begin
         e  = exp_q.pop_front();
         ok = (act.kind === e.kind);
         if (ok) begin
            case (e.kind)
               K_GRANT: ok = (act.addr === e.addr);
               K_ISSUE: ok = (act.we === e.we) && (act.addr === e.addr) && (!e.we || act.dat === e.dat);
               K_LDV:   ok = (act.fwd === e.fwd) && (act.dat === e.dat);
               default: ok = (act.addr === e.addr);
            endcase
         end
         if (ok) n_pass++;
         else $display("FAIL sb_event: got kind=%0d we=%0d fwd=%0d addr=%h dat=%h, expected kind=%0d we=%0d fwd=%0d addr=%h dat=%h (t=%0t)",
                       act.kind, act.we, act.fwd, act.addr, act.dat, e.kind, e.we, e.fwd, e.addr, e.dat, $time);
      end
   endtask

   // Monitor: every observable DUT event is matched against the expectation queue.
   always @(negedge clk) begin
      if (!rst) begin
         req_prev <= 1'b0;
         sd_seen  <= 1'b0;
      end else begin
         if (ld_valid) cmp_ev(mk_ev(K_LDV, 1'b0, ld_fwd, '0, ld_data));
         if (ld_grant) cmp_ev(mk_ev(K_GRANT, 1'b0, 1'b0, ld_addr, '0));
         if (mem_req && !req_prev) cmp_ev(mk_ev(K_ISSUE, mem_we, 1'b0, mem_addr, mem_wdata));
         if (st_done) cmp_ev(mk_ev(K_STD, 1'b0, 1'b0, mem_addr, '0));
         req_prev <= mem_req;
         sd_seen  <= st_done;
      end
   end

   // Advance to just after the next rising edge; models store-buffer clear and memory ack.
   task automatic step();
      @(posedge clk);
      #1;
      if (sd_seen) st_valid = 1'b0;
      if (mem_req && !mem_ack) begin
         if (wait_cnt == ack_dly) begin
            mem_ack   = 1'b1;
            mem_rdata = rd_val;
            wait_cnt  = 0;
         end else begin
            wait_cnt++;
         end
      end else begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end
   endtask

   task automatic drain(string name);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         step();
         @(negedge clk);
         if (!busy && !st_valid && !mem_req && !ld_req && !mem_ack) done = 1'b1;
      end
      chk(name, {63'd0, done}, 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

   initial begin
      int grants;
      rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
      ld_req = 1'b0; ld_addr = '0; mem_ack = 1'b0; mem_rdata = '0;

      // Reset state
      step(); step();
      @(negedge clk);
      chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
      chk("rst_mem_fields", {mem_we, mem_addr, mem_wdata}, 64'd0);
      chk("rst_ld_outs", {ld_valid, ld_fwd, ld_data}, 64'd0);
      chk("rst_busy_grant_done", {busy, ld_grant, st_done}, 64'd0);
      step();
      rst = 1'b1;
      @(negedge clk);

      // Single load, memory acks in the first request cycle
      ack_dly = 0; rd_val = 33'h0_DEADBEEF;
      exp_q.push_back(mk_ev(K_GRANT, 1'b0, 1'b0, 5'h03, '0));
      exp_q.push_back(mk_ev(K_ISSUE, 1'b0, 1'b0, 5'h03, '0));
      exp_q.push_back(mk_ev(K_LDV,   1'b0, 1'b0, '0, 33'h0_DEADBEEF));
      step();
      ld_req = 1'b1; ld_addr = 5'h03;
      @(negedge clk);
      chk("ld_grant_N", {63'd0, ld_grant}, 64'd1);
      step();
      ld_req = 1'b0;
      @(negedge clk);
      chk("ld_req_N1", {mem_req, mem_we, mem_addr}, {59'd0, 1'b1, 1'b0, 5'h03});
      step();
      @(negedge clk);
      chk("ld_valid_N2", {ld_valid, ld_fwd, ld_data}, {29'd0, 1'b1, 1'b0, 33'h0_DEADBEEF});
      drain("drain_load");

      // Single store with a 3-cycle memory stall
      ack_dly = 3;
      exp_q.push_back(mk_ev(K_ISSUE, 1'b1, 1'b0, 5'h1F, 33'h1_00000001));
      exp_q.push_back(mk_ev(K_STD,   1'b0, 1'b0, 5'h1F, '0));
      step();
      st_valid = 1'b1; st_addr = 5'h1F; st_data = 33'h1_00000001;
      @(negedge clk);
      chk("st_no_grant", {ld_grant, st_done}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         chk("st_stall_fields", {mem_req, mem_we, st_done, mem_addr, mem_wdata},
             {22'd0, 1'b1, 1'b1, 1'b0, 5'h1F, 33'h1_00000001});
      end
      step();
      @(negedge clk);
      chk("st_done_with_ack", {mem_ack, st_done, mem_req}, {61'd0, 3'b111});
      step();
      @(negedge clk);
      chk("st_back_idle", {busy, st_done, mem_req, st_valid}, 64'd0);
      ack_dly = 0;

      // Forwarding from the pending store
      exp_q.push_back(mk_ev(K_GRANT, 1'b0, 1'b0, 5'h0A, '0));
      exp_q.push_back(mk_ev(K_LDV,   1'b0, 1'b1, '0, 33'h0_12345678));
      exp_q.push_back(mk_ev(K_ISSUE, 1'b1, 1'b0, 5'h0A, 33'h0_12345678));
      exp_q.push_back(mk_ev(K_STD,   1'b0, 1'b0, 5'h0A, '0));
      step();
      st_valid = 1'b1; st_addr = 5'h0A; st_data = 33'h0_12345678;
      ld_req = 1'b1; ld_addr = 5'h0A;
      @(negedge clk);
      chk("fwd_grant", {ld_grant, mem_req}, 64'd2);
      step();
      ld_req = 1'b0;
      @(negedge clk);
      chk("fwd_valid", {ld_valid, ld_fwd, mem_req, busy, ld_data}, {27'd0, 4'b1100, 33'h0_12345678});
      drain("drain_fwd");

      // Starvation bound: four loads, then the pending store must win
      rd_val = 33'h0_CAFE0002;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(mk_ev(K_GRANT, 1'b0, 1'b0, 5'h02, '0));
         exp_q.push_back(mk_ev(K_ISSUE, 1'b0, 1'b0, 5'h02, '0));
         exp_q.push_back(mk_ev(K_LDV,   1'b0, 1'b0, '0, 33'h0_CAFE0002));
      end
      exp_q.push_back(mk_ev(K_ISSUE, 1'b1, 1'b0, 5'h01, 33'h1_5555AAAA));
      exp_q.push_back(mk_ev(K_STD,   1'b0, 1'b0, 5'h01, '0));
      grants = 0;
      step();
      st_valid = 1'b1; st_addr = 5'h01; st_data = 33'h1_5555AAAA;
      ld_req = 1'b1; ld_addr = 5'h02;
      for (int i = 0; i < 60 && ld_req; i++) begin
         @(negedge clk);
         if (ld_grant) grants++;
         step();
         if (!st_valid) ld_req = 1'b0;
      end
      chk("starve_store_drained", {63'd0, ld_req}, 64'd0);
      chk("starve_grant_count", 64'(grants), 64'd4);
      @(negedge clk);
      drain("drain_starve");

      // Simultaneous store and load, different addresses: load first
      rd_val = 33'h0_0BADF00D;
      exp_q.push_back(mk_ev(K_GRANT, 1'b0, 1'b0, 5'h07, '0));
      exp_q.push_back(mk_ev(K_ISSUE, 1'b0, 1'b0, 5'h07, '0));
      exp_q.push_back(mk_ev(K_LDV,   1'b0, 1'b0, '0, 33'h0_0BADF00D));
      exp_q.push_back(mk_ev(K_ISSUE, 1'b1, 1'b0, 5'h04, 33'h0_77777777));
      exp_q.push_back(mk_ev(K_STD,   1'b0, 1'b0, 5'h04, '0));
      step();
      st_valid = 1'b1; st_addr = 5'h04; st_data = 33'h0_77777777;
      ld_req = 1'b1; ld_addr = 5'h07;
      @(negedge clk);
      chk("both_ld_grant", {63'd0, ld_grant}, 64'd1);
      step();
      ld_req = 1'b0;
      @(negedge clk);
      chk("both_load_first", {mem_req, mem_we}, 64'd2);
      step();
      @(negedge clk);
      chk("both_ld_valid", {63'd0, ld_valid}, 64'd1);
      step();
      @(negedge clk);
      chk("both_store_next", {mem_req, mem_we, mem_addr}, {59'd0, 2'b11, 5'h04});
      drain("drain_both");

      // Reset in the middle of a stalled store
      ack_dly = 20;
      exp_q.push_back(mk_ev(K_ISSUE, 1'b1, 1'b0, 5'h11, 33'h1_0F0F0F0F));
      step();
      st_valid = 1'b1; st_addr = 5'h11; st_data = 33'h1_0F0F0F0F;
      @(negedge clk);
      step();
      @(negedge clk);
      chk("mid_busy_before", {busy, mem_req}, 64'd3);
      #2;
      rst = 1'b0;
      st_valid = 1'b0;
      #1;
      chk("mid_rst_immediate", {busy, mem_req, mem_we}, 64'd0);
      chk("mid_rst_ld_data", {31'd0, ld_data}, 64'd0);
      step();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         @(negedge clk);
         chk("mid_rst_quiet", {st_done, mem_req, busy, ld_valid}, 64'd0);
      end

      chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
